lsu: RTL and testbench
======================

Name: lsu

Overview:
Load/store unit between the core's memory stage and the data memory port.
- Converts core load/store requests (address, funct3 size/sign, write data) into word-addressed memory transactions with byte enables and lane-replicated write data.
- Stalls the core until the memory completes.
- Extracts and sign- or zero-extends read data.
- Rejects misaligned or illegal accesses without touching memory.

Parameters:
- none. Size codes are fixed: LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core access request; held stable while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  funct3 size/sign code
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  extended load data, valid in the completion cycle
- core_stall_o  out  1  core must hold its request and stall
- core_misalign_o  out  1  request rejected (misaligned or illegal size)
- mem_req_o  out  1  memory request, one cycle per access
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  memory address, equal to core_addr_i
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word, valid when mem_ready_i=1 in WAIT
- mem_ready_i  in  1  memory completion

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous, active-low; it forces state IDLE and clears the captured size and offset.
- Outputs during reset: mem_req_o=0, core_stall_o=0, core_misalign_o=0, core_rd_o=0.
- State IDLE:
  - core_req_i=1, legal: mem_req_o=1, core_stall_o=1. Capture core_size_i and core_addr_i[1:0] into registers. Next state WAIT.
  - core_req_i=1, illegal: combinationally core_misalign_o=1, core_stall_o=0, mem_req_o=0. Stay in IDLE.
  - core_req_i=0: all outputs 0.
- State WAIT:
  - mem_req_o=0, so the access is issued exactly once.
  - core_stall_o = ~mem_ready_i.
  - On mem_ready_i=1: core_rd_o = extracted mem_rd_i for a load, 0 for a store. Next state IDLE.
  - On mem_ready_i=0: remain in WAIT with core_stall_o=1.
- Latency: with an always-ready memory, a 2-cycle access. Cycle N issues the request; cycle N+1 completes with core_stall_o=0.
- Illegal accesses:
  - Size 3, 6 or 7.
  - H or HU with addr[0]=1.
  - W with addr[1:0]!=0.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 when addr[1]=0, else 4'b1100.
  - W: 4'b1111.
  - Loads drive the same enables; memory ignores them.
- Write data:
  - B: core_wd_i[7:0] replicated ×4.
  - H: core_wd_i[15:0] replicated ×2.
  - W: core_wd_i unchanged.
- Read extraction uses the captured offset and size, not the live inputs:
  - B/BU: byte at lane offset, sign- or zero-extended.
  - H/HU: halfword at lane offset[1], sign- or zero-extended.
  - W: mem_rd_i unchanged.
- mem_we_o = core_we_i. mem_addr_o = core_addr_i in both states; the core holds the address while stalled.
- core_req_i dropping during WAIT is a protocol violation. The LSU still completes the access.
- Back-to-back requests: the completion cycle returns to IDLE. The next request is accepted in the following cycle, so there is one idle cycle between accesses.
- rst_ni asserted in WAIT: immediate return to IDLE and stall released. A memory write already issued is not undone.

Test Plan:
- Store byte: addr=0x103, size=B, wd=0x000000AB, memory always ready → cycle N: mem_req_o=1, mem_be_o=4'b1000, mem_wd_o=0xABABABAB, core_stall_o=1. Cycle N+1: core_stall_o=0, mem_req_o=0.
- Load signed and unsigned byte: mem_rd_i=0x80FF7F01.
  - addr offset 3, LB → core_rd_o=0xFFFFFF80.
  - Same access as LBU → core_rd_o=0x00000080.
  - Offset 1, LB → core_rd_o=0x0000007F.
- Halfword load and store:
  - LH at addr=0x202 with mem_rd_i=0x8001xxxx → core_rd_o=0xFFFF8001.
  - SH at 0x202 with wd=0x1234 → mem_be_o=4'b1100, mem_wd_o=0x12341234.
- Misaligned and illegal requests:
  - LW at addr=0x101 → core_misalign_o=1, core_stall_o=0, mem_req_o=0 for that cycle, state stays IDLE.
  - size=3'd3 → same response.
- Slow memory: hold mem_ready_i=0 for 3 cycles after issue → core_stall_o=1 for 4 cycles total and mem_req_o high only in the first. core_rd_o is valid in the cycle mem_ready_i=1.
- Reset mid-access: assert rst_ni=0 asynchronously during WAIT → core_stall_o=0 and mem_req_o=0 immediately, without waiting for a clock edge. After release, a new LW completes in 2 cycles.

Source files
------------

// File: rtl/lsu.sv
// ============================================================================
// Module      : lsu
// Description : Load/store unit. Turns core load/store requests into single
//               memory transactions and extends the returned read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;

  logic        legal;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        req_d, stall_d, mis_d;
  logic [31:0] rd_d;

  // Request decode from the live inputs: legality, lane enables, replication.
  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wd    = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        legal = 1'b1;
        be    = 4'b0001 << core_addr_i[1:0];
        wd    = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        legal = ~core_addr_i[0];
        be    = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd    = {2{core_wd_i[15:0]}};
      end
      LDST_W: begin
        legal = (core_addr_i[1:0] == 2'b00);
        be    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Read extraction uses the size/offset captured at issue time.
  always_comb begin
    rd_shift = mem_rd_i >> {off_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      LDST_B:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      LDST_BU: rd_ext = {24'h000000, rd_byte};
      LDST_H:  rd_ext = {{16{rd_half[15]}}, rd_half};
      LDST_HU: rd_ext = {16'h0000, rd_half};
      default: rd_ext = mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    we_d    = we_q;
    req_d   = 1'b0;
    stall_d = 1'b0;
    mis_d   = 1'b0;
    rd_d    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          if (legal) begin
            req_d   = 1'b1;
            stall_d = 1'b1;
            size_d  = core_size_i;
            off_d   = core_addr_i[1:0];
            we_d    = core_we_i;
            state_d = S_WAIT;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall_d = ~mem_ready_i;
        if (mem_ready_i) begin
          rd_d    = we_q ? 32'h0 : rd_ext;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must silence the handshake outputs at once, even with a request held.
  assign mem_req_o       = req_d & rst_ni;
  assign core_stall_o    = stall_d & rst_ni;
  assign core_misalign_o = mis_d & rst_ni;
  assign core_rd_o       = rst_ni ? rd_d : 32'h0;

  assign mem_we_o   = core_we_i;
  assign mem_be_o   = be;
  assign mem_wd_o   = wd;
  assign mem_addr_o = core_addr_i;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module      : tb_lsu
// Description : Scoreboard bench for lsu with a behavioural memory/LSU model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd;
  logic [31:0] core_rd;
  logic        core_stall, core_misalign;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;

  lsu dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_req_i     (core_req),
    .core_we_i      (core_we),
    .core_size_i    (core_size),
    .core_addr_i    (core_addr),
    .core_wd_i      (core_wd),
    .core_rd_o      (core_rd),
    .core_stall_o   (core_stall),
    .core_misalign_o(core_misalign),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wd_o       (mem_wd),
    .mem_rd_i       (mem_rd),
    .mem_ready_i    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] addr;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   busy = 1'b0;
  int   scnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: access described by byte count, lane offset and extension rule.
  function automatic exp_t model(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd, input int nwait);
    exp_t e;
    int nb, off;
    logic [31:0] mask, w;
    off = int'(addr[1:0]);
    e.mis = !((sz == 3'd0 || sz == 3'd4) ||
              ((sz == 3'd1 || sz == 3'd5) && (off % 2 == 0)) ||
              (sz == 3'd2 && off == 0));
    nb = 1 << int'(sz[1:0]);
    e.we = we;
    e.addr = addr;
    e.be = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    if (we) begin
      e.rd = 32'h0;
    end else begin
      w = rd >> (8 * off);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      w = w & mask;
      if (!sz[2] && nb < 4 && w[8*nb-1]) w = w | ~mask;
      e.rd = w;
    end
    e.stalls = nwait + 1;
    return e;
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 with the request dropped.
  task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int nwait);
    exp_t e;
    e = model(we, sz, addr, wd, rd, nwait);
    sbq.push_back(e);
    core_req  = 1'b1;
    core_we   = we;
    core_size = sz;
    core_addr = addr;
    core_wd   = wd;
    mem_rd    = rd;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    if (!e.mis) begin
      repeat (nwait) begin
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    core_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (core_misalign) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: unexpected misalign at %0t", $time);
        end else begin
          cur = sbq.pop_front();
          chk("misalign_expected", 32'(cur.mis), 32'd1);
          chk("misalign_req", 32'(mem_req), 32'd0);
          chk("misalign_stall", 32'(core_stall), 32'd0);
        end
      end else if (mem_req) begin
        chk("reissue_while_busy", 32'(busy), 32'd0);
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: unexpected mem_req at %0t", $time);
        end else begin
          cur = sbq.pop_front();
          chk("issue_expected", 32'(cur.mis), 32'd0);
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          chk("mem_wd", mem_wd, cur.wd);
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", mem_addr, cur.addr);
          chk("issue_stall", 32'(core_stall), 32'd1);
          busy = 1'b1;
          scnt = 1;
        end
      end else if (busy) begin
        if (core_stall) begin
          scnt++;
        end else begin
          chk("core_rd", core_rd, cur.rd);
          chk("stall_cycles", 32'(scnt), 32'(cur.stalls));
          busy = 1'b0;
        end
      end else begin
        chk("idle_stall", 32'(core_stall), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_size = 3'd2;
    core_addr = 32'h0; core_wd = 32'h0; mem_rd = 32'h0; mem_ready = 1'b0;
    #3;
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_stall", 32'(core_stall), 32'd0);
    chk("reset_mis", 32'(core_misalign), 32'd0);
    chk("reset_rd", core_rd, 32'd0);
    core_req = 1'b1; core_addr = 32'h100; mem_ready = 1'b1;
    #1;
    chk("reset_req_held", 32'(mem_req), 32'd0);
    chk("reset_stall_held", 32'(core_stall), 32'd0);
    core_req = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0);
    do_txn(1'b0, 3'd0, 32'h0000_0107, 32'h0, 32'h80FF_7F01, 0);
    do_txn(1'b0, 3'd4, 32'h0000_0107, 32'h0, 32'h80FF_7F01, 0);
    do_txn(1'b0, 3'd0, 32'h0000_0105, 32'h0, 32'h80FF_7F01, 0);
    do_txn(1'b0, 3'd1, 32'h0000_0202, 32'h0, 32'h8001_5A5A, 1);
    do_txn(1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234, 32'h0, 0);
    do_txn(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 0);
    do_txn(1'b0, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 0);
    do_txn(1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 3);
    do_txn(1'b0, 3'd5, 32'h0000_0412, 32'h0, 32'hFEDC_BA98, 2);

    // Reset in the middle of a slow access.
    mon_en = 1'b0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2;
    core_addr = 32'h0000_0400; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("wait_stall_before_reset", 32'(core_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_stall", 32'(core_stall), 32'd0);
    chk("async_reset_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    core_req = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 3'd2, 32'h0000_0404, 32'h0, 32'h1357_9BDF, 0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             32'($urandom), 32'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    chk("busy_at_end", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
